// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// sign fix-up in a dedicated cycle, single-cycle completion strobes for the HI/LO registers.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hi_write,
    output logic             lo_write,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        rs_neg    = op[0] & rs[WIDTH-1];
        rt_neg    = op[0] & rt[WIDTH-1];
        rs_abs    = rs_neg ? -rs : rs;
        rt_abs    = rt_neg ? -rt : rt;
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_diff  = div_shift - {1'b0, mag_b};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -quo : quo;
        // Remainder takes the dividend's sign; with a zero divisor this rebuilds the raw dividend.
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        hi_write = done;
        lo_write = done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    count       <= '0;
                    is_div      <= op[1];
                    neg_q       <= rs_neg ^ rt_neg;
                    neg_r       <= rs_neg;
                    zero_div    <= op[1] && (rt == '0);
                    mag_a       <= rs_abs;
                    mag_b       <= rt_abs;
                    prod        <= {{WIDTH{1'b0}}, rt_abs};
                    rem         <= '0;
                    quo         <= rs_abs;
                    div_by_zero <= 1'b0;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        rem <= div_ge ? div_diff : div_shift;
                        quo <= {quo[WIDTH-2:0], div_ge};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (zero_div) begin
                        hi          <= rem_fix;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of operations with hand-computed results,
// plus sequences for ignored starts, mid-run reset and reset/start collision.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [1:0] MULU = 2'b00, MUL = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         busy, done, hi_write, lo_write, div_by_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .hi_write(hi_write), .lo_write(lo_write), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic       dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT idle.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edbz);
        int cyc = 0;
        bit seen = 0;
        bit busy_bad = 0;
        op = o; rs = a; rt = b; start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, ".busy_after_start"}, 32'(busy), 32'd1);
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (done) seen = 1;
            else if (!busy) busy_bad = 1;
        end
        check({nm, ".latency"}, 32'(cyc), 32'd33);
        check({nm, ".busy_while_running"}, 32'(busy_bad), 32'd0);
        check({nm, ".hi"}, hi, eh);
        check({nm, ".lo"}, lo, el);
        check({nm, ".dbz"}, 32'(div_by_zero), 32'(edbz));
        check({nm, ".strobes"}, {29'd0, hi_write, lo_write, busy}, 32'b110);
        tick();
        check({nm, ".after_done"}, {29'd0, done, hi_write, busy}, 32'd0);
        check({nm, ".dbz_held"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        int n_done;
        bit hold_bad;
        logic [31:0] hold_hi, hold_lo;

        vecs[0]  = '{"mulu_max",   MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{"mul_neg3x7", MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{"mul_minsq",  MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{"divu_100_7", DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[4]  = '{"div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{"div_7_m2",   DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{"divu_zero",  DIVU, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{"div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{"div_zero_s", DIV,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{"mul_m1xm1",  MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{"mulu_split", MULU, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000, 1'b0};
        vecs[11] = '{"div_m100_7", DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        check("reset.outputs", {25'd0, busy, done, hi_write, lo_write, div_by_zero, 2'b00}, 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        tick();

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);

        // Starts issued mid-operation must be ignored.
        op = MULU; rs = 32'd6; rt = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (c == 5 || c == 20) begin
                op = DIVU; rs = 32'd999; rt = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                check("ignore_start.latency", 32'(c), 32'd33);
                check("ignore_start.hi", hi, 32'd0);
                check("ignore_start.lo", lo, 32'd42);
            end
        end
        start = 1'b0;
        check("ignore_start.done_count", 32'(n_done), 32'd1);
        hold_bad = 0;
        hold_hi = 32'd0; hold_lo = 32'd42;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (hi !== hold_hi || lo !== hold_lo || done !== 1'b0) hold_bad = 1;
        end
        check("hold.hi_lo", 32'(hold_bad), 32'd0);

        // Reset partway through RUN aborts the operation with no done pulse.
        op = DIVU; rs = 32'd1000; rt = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("abort.no_activity", 32'(n_done), 32'd0);
        run_op("divu_1000_3", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Reset and start together: reset wins.
        op = MULU; rs = 32'd5; rt = 32'd5; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        check("reset_start.busy", 32'(busy), 32'd0);
        check("reset_start.lo", lo, 32'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("reset_start.no_activity", 32'(n_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
